alu_sequencer: RTL

//  Multi-cycle control FSM for the 8-bit computer. Fetches one 8-bit

---
 rtl/alu_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/exec/writeback controller for the
// 8-bit computer. Fetches over an ack'd instruction port, drives the ALU
// control and register select, pulses the SAR write and steps/branches the PC.
// Optional single-step mode: define CTRL_STEP_EN to add the step input and a
// PAUSE state entered after every writeback.
module alu_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int FETCH_TO = 15
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CTRL_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [2:0]      rf_rsel,
  output logic [1:0]      alu_control,
  input  logic            alu_branch,
  output logic            sar_we,
  output logic            halted,
  output logic            fault,
  output logic [7:0]      retired
);

  // Wait counter only needs to reach FETCH_TO-1 before the timeout fires.
  localparam int TO_W = (FETCH_TO < 2) ? 1 : $clog2(FETCH_TO);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TO - 1);
  localparam logic [7:0]      HALT_OP = 8'hFF;
  localparam logic [1:0]      OP_BNZ  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
`ifdef CTRL_STEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              branch_q, branch_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]        rsel_q, rsel_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [7:0]        retired_q, retired_d;
  logic [PC_W-1:0]   imm_sext;

  assign imm_sext = {{(PC_W-3){ir_q[2]}}, ir_q[2:0]};

  // Next-state logic; rsel/ctrl are loaded on the accepting fetch edge so that
  // they are already registered and stable during DECODE, EXEC and WB.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    branch_d  = branch_q;
    cnt_d     = cnt_q;
    rsel_d    = rsel_q;
    ctrl_d    = ctrl_q;
    retired_d = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          cnt_d   = '0;
          state_d = S_DECODE;
          if (imem_data != HALT_OP) begin
            rsel_d = imem_data[5:3];
            ctrl_d = imem_data[7:6];
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (ir_q == HALT_OP) begin
          retired_d = retired_q + 8'd1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        branch_d = alu_branch;
        state_d  = S_WB;
      end
      S_WB: begin
        if ((ir_q[7:6] == OP_BNZ) && branch_q) begin
          pc_d = pc_q + imm_sext;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        retired_d = retired_q + 8'd1;
`ifdef CTRL_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef CTRL_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= '0;
      branch_q  <= 1'b0;
      cnt_q     <= '0;
      rsel_q    <= '0;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      branch_q  <= branch_d;
      cnt_q     <= cnt_d;
      rsel_q    <= rsel_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are gated by rst so that a reset cycle never requests or writes.
  always_comb begin
    imem_req    = (state_q == S_FETCH) && !rst;
    sar_we      = (state_q == S_WB) && (ir_q[7:6] != OP_BNZ) && !rst;
    imem_addr   = pc_q;
    rf_rsel     = rsel_q;
    alu_control = ctrl_q;
    halted      = (state_q == S_HALT);
    fault       = (state_q == S_FAULT);
    retired     = retired_q;
  end

endmodule
